// File: rtl/mem_wb_pipe_if.sv
// Handshake bundle between the memory stage, the mem_wb_pipe register and the write-back port.
// The bench or upstream logic takes the master side; the pipeline register takes the slave side.
interface mem_wb_pipe_if #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 2,
  parameter int INSTR_W    = 32,
  parameter int WEN_W      = 2,
  parameter int ADDR_W     = 14,
  parameter int HIST_DEPTH = 1
) ();
  logic                             in_valid;
  logic                             in_ready;
  logic [LANES*DATA_W-1:0]          data_in;
  logic [INSTR_W-1:0]               instruction_in;
  logic [WEN_W-1:0]                 reg_file_wen_in;
  logic [ADDR_W-1:0]                ret_addr_in;
  logic                             out_valid;
  logic                             out_ready;
  logic [LANES*DATA_W-1:0]          data_out;
  logic [INSTR_W-1:0]               instruction_out;
  logic [WEN_W-1:0]                 reg_file_wen_out;
  logic [ADDR_W-1:0]                ret_addr_out;
  logic [HIST_DEPTH*LANES*DATA_W-1:0] data_hist;

  modport master (
    output in_valid, data_in, instruction_in, reg_file_wen_in, ret_addr_in, out_ready,
    input  in_ready, out_valid, data_out, instruction_out, reg_file_wen_out, ret_addr_out,
           data_hist
  );

  modport slave (
    input  in_valid, data_in, instruction_in, reg_file_wen_in, ret_addr_in, out_ready,
    output in_ready, out_valid, data_out, instruction_out, reg_file_wen_out, ret_addr_out,
           data_hist
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// Memory/write-back stage register: ready/valid with a two-entry skid buffer, flush and commit history.
// Define MEM_WB_PIPE_HIST_EN to build the committed-data history; otherwise data_hist reads 0.
module mem_wb_pipe #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 2,
  parameter int INSTR_W    = 32,
  parameter int WEN_W      = 2,
  parameter int ADDR_W     = 14,
  parameter int HIST_DEPTH = 1
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         flush,
  mem_wb_pipe_if.slave bus
);
  localparam int DW = LANES * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [INSTR_W-1:0]  main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic [WEN_W-1:0]    main_wen_q, main_wen_d, skid_wen_q, skid_wen_d;
  logic [ADDR_W-1:0]   main_ret_q, main_ret_d, skid_ret_q, skid_ret_d;

  logic in_fire, out_fire;
  logic main_from_in, main_from_skid, skid_load;

  // in_ready is a pure decode of the state register, never of out_ready.
  assign bus.in_ready  = (state_q != SKID);
  assign bus.out_valid = (state_q != EMPTY);
  assign in_fire       = bus.in_valid & bus.in_ready & ~flush;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d      = FULL;
          main_from_in = 1'b1;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          main_from_in = 1'b1;
        end else if (in_fire) begin
          state_d   = SKID;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (out_fire) begin
          state_d        = FULL;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // in_fire is already masked by flush, so only the skid refill needs cancelling here.
    if (flush) begin
      state_d        = EMPTY;
      main_from_skid = 1'b0;
    end
  end

  always_comb begin
    main_data_d  = main_data_q;
    main_instr_d = main_instr_q;
    main_wen_d   = main_wen_q;
    main_ret_d   = main_ret_q;
    skid_data_d  = skid_data_q;
    skid_instr_d = skid_instr_q;
    skid_wen_d   = skid_wen_q;
    skid_ret_d   = skid_ret_q;
    if (main_from_in) begin
      main_data_d  = bus.data_in;
      main_instr_d = bus.instruction_in;
      main_wen_d   = bus.reg_file_wen_in;
      main_ret_d   = bus.ret_addr_in;
    end else if (main_from_skid) begin
      main_data_d  = skid_data_q;
      main_instr_d = skid_instr_q;
      main_wen_d   = skid_wen_q;
      main_ret_d   = skid_ret_q;
    end
    if (skid_load) begin
      skid_data_d  = bus.data_in;
      skid_instr_d = bus.instruction_in;
      skid_wen_d   = bus.reg_file_wen_in;
      skid_ret_d   = bus.ret_addr_in;
    end
    // Only the enables must be scrubbed on flush; stale data is harmless once wen is 0.
    if (flush) begin
      main_wen_d = '0;
      skid_wen_d = '0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_instr_q <= '0;
      main_wen_q   <= '0;
      main_ret_q   <= '0;
      skid_data_q  <= '0;
      skid_instr_q <= '0;
      skid_wen_q   <= '0;
      skid_ret_q   <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_instr_q <= main_instr_d;
      main_wen_q   <= main_wen_d;
      main_ret_q   <= main_ret_d;
      skid_data_q  <= skid_data_d;
      skid_instr_q <= skid_instr_d;
      skid_wen_q   <= skid_wen_d;
      skid_ret_q   <= skid_ret_d;
    end
  end

  assign bus.data_out         = main_data_q;
  assign bus.instruction_out  = main_instr_q;
  assign bus.reg_file_wen_out = main_wen_q & {WEN_W{bus.out_valid}};
  assign bus.ret_addr_out     = main_ret_q;

`ifdef MEM_WB_PIPE_HIST_EN
  logic [HIST_DEPTH-1:0][DW-1:0] hist_q, hist_d;

  // A commit in a flush cycle still counts, so history keys only on out_fire.
  always_comb begin
    hist_d = hist_q;
    if (out_fire) begin
      hist_d[0] = main_data_q;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign bus.data_hist = hist_q;
`else
  assign bus.data_hist = '0;
`endif

endmodule
